pio_uart_tx: RTL and testbench

Parametrised UART transmitter fed from an HPS-written PIO register, driving one FPGA GPIO pin as serial TX. It replaces the fixed 8-bit single-shot serial writer with the following:
- configurable data width and FIFO depth;
- runtime baud divisor, parity and stop-bit selection;
- edge-triggered write strobe, status flags and a sticky overflow flag readable back through PIO.
It sits between soc_system PIO exports and GPIO_0.

---
 rtl/pio_uart_tx_if.sv | 34 +++
 rtl/pio_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_pio_uart_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_uart_tx_if.sv
// Bus bundle between the HPS PIO exports and the UART transmitter.
// The master drives the PIO-written controls, the slave returns the status flags.
`timescale 1ns/1ps
interface pio_uart_tx_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_req;
  logic [DIV_W-1:0]  baud_div;
  logic [1:0]        parity_mode;
  logic              stop2;
  logic              tx_en;
  logic              ovf_clr;
  logic              tx;
  logic              busy;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              overflow;

  modport master (
    output wr_data, wr_req, baud_div, parity_mode, stop2, tx_en, ovf_clr,
    input  tx, busy, fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  wr_data, wr_req, baud_div, parity_mode, stop2, tx_en, ovf_clr,
    output tx, busy, fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface

// File: rtl/pio_uart_tx.sv
// UART transmitter fed by an edge-triggered PIO write strobe through a TX FIFO.
// Baud divisor, parity and stop bits are latched per frame when the frame starts.
`timescale 1ns/1ps
module pio_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  pio_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              wr_req_q, full_q, empty_q, ovf_q, busy_q, tx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DIV_W-1:0]  div_q, cnt_q, div_sel_s;
  logic [3:0]        bit_q;
  logic              par_en_q, par_bit_q, stop2_q, stop_last_q;
  logic              push_s, pop_s, wr_en_s, ovf_set_s, frame_end_s, idle_next_s;

  // Strobe edge detect, FIFO handshake and next-state status terms
  always_comb begin
    push_s      = bus.wr_req & ~wr_req_q;
    pop_s       = (state_q == IDLE) & bus.tx_en & ~empty_q;
    wr_en_s     = push_s & (~full_q | pop_s);
    ovf_set_s   = push_s & full_q & ~pop_s;
    count_d     = count_q + CW'(wr_en_s) - CW'(pop_s);
    div_sel_s   = (bus.baud_div < DIV_W'(2)) ? DIV_W'(2) : bus.baud_div;
    frame_end_s = (state_q == STOP) & (cnt_q == DIV_W'(0)) & ~(stop2_q & ~stop_last_q);
    idle_next_s = ((state_q == IDLE) & ~pop_s) | frame_end_s;
  end

  // FIFO storage; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q <= 1'b1;
      wptr_q   <= AW'(0);
      rptr_q   <= AW'(0);
      count_q  <= CW'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_req_q <= bus.wr_req;
      if (wr_en_s) wptr_q <= wptr_q + AW'(1);
      if (pop_s)   rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == CW'(FIFO_DEPTH));
      empty_q  <= (count_d == CW'(0));
      if (bus.ovf_clr)  ovf_q <= 1'b0;
      else if (ovf_set_s) ovf_q <= 1'b1;
      busy_q   <= ~idle_next_s | (count_d != CW'(0));
    end
  end

  // Frame sequencer; tx_q is registered from the current state, one clock behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= DATA_W'(0);
      div_q       <= DIV_W'(2);
      cnt_q       <= DIV_W'(0);
      bit_q       <= 4'd0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_last_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop_s) begin
            shift_q     <= mem_q[rptr_q];
            div_q       <= div_sel_s;
            cnt_q       <= div_sel_s - DIV_W'(1);
            par_en_q    <= (bus.parity_mode == 2'b01) | (bus.parity_mode == 2'b10);
            par_bit_q   <= (^mem_q[rptr_q]) ^ (bus.parity_mode == 2'b10);
            stop2_q     <= bus.stop2;
            stop_last_q <= 1'b0;
            bit_q       <= 4'd0;
            state_q     <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (cnt_q == DIV_W'(0)) begin
            cnt_q   <= div_q - DIV_W'(1);
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (cnt_q == DIV_W'(0)) begin
            cnt_q   <= div_q - DIV_W'(1);
            shift_q <= shift_q >> 1;
            if (bit_q == 4'(DATA_W - 1)) begin
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        PARITY: begin
          tx_q <= par_bit_q;
          if (cnt_q == DIV_W'(0)) begin
            cnt_q   <= div_q - DIV_W'(1);
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == DIV_W'(0)) begin
            if (stop2_q & ~stop_last_q) begin
              stop_last_q <= 1'b1;
              cnt_q       <= div_q - DIV_W'(1);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_pio_uart_tx.sv
// Scoreboard bench for pio_uart_tx: writes queue expected frames, a monitor
// decodes every frame on tx sample by sample and compares against the queue.
`timescale 1ns/1ps
module tb_pio_uart_tx;
  localparam int DATA_W = 8, FIFO_DEPTH = 16, DIV_W = 16;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] par;
    logic       s2;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  frame_t exp_q[$];
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;

  pio_uart_tx_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) bus ();
  pio_uart_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 2 : int'(d);
  endfunction

  task automatic push(input logic [7:0] d, input bit expect_it);
    @(negedge clk);
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    if (expect_it)
      exp_q.push_back('{data: d, div: eff_div(bus.baud_div), par: bus.parity_mode, s2: bus.stop2});
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    check(name, int'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fall(output int n);
    logic prev;
    bit   found = 1'b0;
    prev = bus.tx;
    n = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      n++;
      if (prev && !bus.tx) found = 1'b1;
      prev = bus.tx;
    end
    if (!found) check("tx_fall_timeout", 0, 1);
  endtask

  // Monitor: on every tx fall pop the expected frame and check each clock of it
  initial begin : monitor
    frame_t      e;
    logic [15:0] bits;
    int          nb;
    bit          ok, aborted;
    logic        prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !bus.tx) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          bits = 16'hFFFF;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
          nb = 9;
          if (e.par == 2'b01) begin bits[nb] = ^e.data;  nb++; end
          if (e.par == 2'b10) begin bits[nb] = ~^e.data; nb++; end
          nb += e.s2 ? 2 : 1;
          ok = 1'b1;
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c < e.div && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!rst_n) aborted = 1'b1;
              else if (bus.tx !== bits[b]) ok = 1'b0;
            end
          end
          if (!aborted) begin
            tests++;
            if (!ok) begin
              fails++;
              $display("FAIL frame: data 0x%02h div %0d par %0d stop2 %0d, tx waveform differs from expected bits %b (%0d bits)",
                       e.data, e.div, e.par, e.s2, bits, nb);
            end
          end
        end
      end
      prev = bus.tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, n;
    bus.wr_req = 1'b0; bus.wr_data = 8'h00; bus.baud_div = 16'd4; bus.parity_mode = 2'b00;
    bus.stop2 = 1'b0; bus.tx_en = 1'b1; bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(bus.tx), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_full", int'(bus.fifo_full), 0);
    check("rst_empty", int'(bus.fifo_empty), 1);
    check("rst_count", int'(bus.fifo_count), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, div 4, no parity: latency from push edge to tx fall
    @(negedge clk);
    bus.wr_data = 8'hA5; bus.wr_req = 1'b1;
    exp_q.push_back('{data: 8'hA5, div: 4, par: 2'b00, s2: 1'b0});
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (!bus.tx) break;
    end
    check("latency", lat, 2);
    @(negedge clk);
    bus.wr_req = 1'b0;
    check("busy_mid_frame", int'(bus.busy), 1);
    check("empty_mid_frame", int'(bus.fifo_empty), 1);
    wait_idle("drain_a5");
    check("busy_after", int'(bus.busy), 0);

    // Parity even, then odd with two stop bits
    bus.parity_mode = 2'b01;
    push(8'hA5, 1'b1);
    wait_idle("drain_even");
    bus.parity_mode = 2'b10; bus.stop2 = 1'b1;
    push(8'hA5, 1'b1);
    wait_idle("drain_odd");

    // Frame length with odd parity and two stop bits: fall-to-fall = 48 + 1 idle
    bus.tx_en = 1'b0;
    push(8'hFF, 1'b1);
    push(8'hFF, 1'b1);
    @(negedge clk);
    bus.tx_en = 1'b1;
    wait_fall(n);
    wait_fall(n);
    check("frame_len_48", n, 49);
    wait_idle("drain_len");

    // Divisor 0 and 1 behave as 2
    bus.parity_mode = 2'b00; bus.stop2 = 1'b0; bus.baud_div = 16'd0;
    push(8'h3C, 1'b1);
    wait_idle("drain_div0");
    bus.baud_div = 16'd1;
    push(8'hC3, 1'b1);
    wait_idle("drain_div1");

    // Divisor change mid-frame applies only to the next frame
    bus.baud_div = 16'd4;
    push(8'h5A, 1'b1);
    wait_fall(n);
    bus.baud_div = 16'd8;
    push(8'h96, 1'b1);
    wait_idle("drain_divchg");

    // Fill FIFO with transmitter disabled, overflow on the 17th push
    bus.tx_en = 1'b0; bus.baud_div = 16'd2;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    push(8'h10, 1'b0);
    @(negedge clk);
    check("full_flag", int'(bus.fifo_full), 1);
    check("full_count", int'(bus.fifo_count), 16);
    check("full_empty", int'(bus.fifo_empty), 0);
    check("ovf_set", int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    check("ovf_clr", int'(bus.overflow), 0);

    // Push on the same edge as the first pop while full
    @(negedge clk);
    bus.tx_en = 1'b1; bus.wr_data = 8'h10; bus.wr_req = 1'b1;
    exp_q.push_back('{data: 8'h10, div: 2, par: 2'b00, s2: 1'b0});
    @(negedge clk);
    bus.wr_req = 1'b0;
    check("pushpop_count", int'(bus.fifo_count), 16);
    check("pushpop_full", int'(bus.fifo_full), 1);
    check("pushpop_ovf", int'(bus.overflow), 0);
    wait_idle("drain_fifo");

    // Reset during data bit 3 with 3 entries still queued
    bus.tx_en = 1'b0; bus.baud_div = 16'd4;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    @(negedge clk);
    bus.tx_en = 1'b1;
    wait_fall(n);
    repeat (17) @(negedge clk);
    check("pre_rst_count", int'(bus.fifo_count), 3);
    bus.wr_data = 8'h55; bus.wr_req = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_tx", int'(bus.tx), 1);
    check("arst_count", int'(bus.fifo_count), 0);
    check("arst_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("held_req_count", int'(bus.fifo_count), 0);
    check("held_req_empty", int'(bus.fifo_empty), 1);
    check("held_req_busy", int'(bus.busy), 0);
    bus.wr_req = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_tx", int'(bus.tx), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
